// File: rtl/bcd_pkg.sv
// Shared BCD definitions: controller state encoding, digit constants and
// a digit validity helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with decimal correction; purely combinational.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] digit_c,
  output logic       cout_c
);

  logic [4:0] sum_c;

  assign sum_c = 5'(x) + 5'(y) + 5'(cin);

  // Binary sums above nine wrap into the next decade by adding six.
  always_comb begin
    digit_c = sum_c[3:0];
    cout_c  = 1'b0;
    if (sum_c > 5'(BCD_MAX)) begin
      digit_c = 4'(sum_c + 5'(BCD_CORR));
      cout_c  = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit BCD add/subtract sequencer: one digit per clock, LSD first,
// time-sharing a single digit adder with a registered inter-digit carry.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                err
);

  localparam int unsigned W = 4 * DIGITS;

  state_t           state, state_n;
  logic [W-1:0]     a_sh, a_sh_n, b_sh, b_sh_n, result_n;
  logic             sub_q, sub_n, carry, carry_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n, cout_n, err_n;
  logic             operand_bad_c;
  logic [3:0]       y_c, digit_c;
  logic             digit_cout_c;

  // Any non-BCD digit in either operand aborts straight to DONE.
  always_comb begin
    operand_bad_c = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(a[4*i +: 4]) || !is_bcd_digit(b[4*i +: 4])) begin
        operand_bad_c = 1'b1;
      end
    end
  end

  // Subtraction adds the nine's complement with an initial carry of one.
  assign y_c = sub_q ? (BCD_MAX - b_sh[3:0]) : b_sh[3:0];

  bcd_digit_add u_digit_add (
    .x       (a_sh[3:0]),
    .y       (y_c),
    .cin     (carry),
    .digit_c (digit_c),
    .cout_c  (digit_cout_c)
  );

  always_comb begin
    state_n  = state;
    a_sh_n   = a_sh;
    b_sh_n   = b_sh;
    sub_n    = sub_q;
    carry_n  = carry;
    cnt_n    = cnt;
    result_n = result;
    cout_n   = cout;
    err_n    = err;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_sh_n   = a;
          b_sh_n   = b;
          sub_n    = op_sub;
          carry_n  = op_sub;
          cnt_n    = '0;
          result_n = '0;
          cout_n   = 1'b0;
          err_n    = operand_bad_c;
          state_n  = operand_bad_c ? DONE : RUN;
        end
      end
      RUN: begin
        result_n = {digit_c, result[W-1:4]};
        carry_n  = digit_cout_c;
        a_sh_n   = a_sh >> 4;
        b_sh_n   = b_sh >> 4;
        cnt_n    = CNT_W'(cnt + 1'b1);
        if (cnt == CNT_W'(DIGITS - 1)) begin
          cout_n  = digit_cout_c;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      a_sh   <= a_sh_n;
      b_sh   <= b_sh_n;
      sub_q  <= sub_n;
      carry  <= carry_n;
      cnt    <= cnt_n;
      result <= result_n;
      cout   <= cout_n;
      err    <= err_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: directed operations push expected
// results; a monitor pops and compares on every done pulse.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         err;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("cout",   32'(cout),   32'(e.cout));
        check("err",    32'(err),    32'(e.err));
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] res, input logic c, input logic e);
    exp_t x;
    x.res  = res;
    x.cout = c;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    a      = ia;
    b      = ib;
    op_sub = isub;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the start edge until done; busy must be up at once.
  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) check({name, "_busy"}, 32'(busy), 32'(1));
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check({name, "_timeout"}, 32'(0), 32'(1));
    else          check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic post_check(input string name, input logic [W-1:0] exp_res);
    @(negedge clk);
    check({name, "_done_low"}, 32'(done), 32'(0));
    check({name, "_idle"},     32'(busy), 32'(0));
    check({name, "_held"},     32'(result), 32'(exp_res));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic [W-1:0] res, input logic c,
                        input logic e, input int lat);
    push_exp(res, c, e);
    issue(ia, ib, isub);
    wait_done(name, lat);
    post_check(name, res);
  endtask

  task automatic no_done_for(input string name, input int cycles);
    int nd = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) nd++;
    end
    check(name, 32'(nd), 32'(0));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(busy),   32'(0));
    check("rst_done",   32'(done),   32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_cout",   32'(cout),   32'(0));
    check("rst_err",    32'(err),    32'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    run_op("add_basic", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, DIGITS + 1);

    // Wrap-around, then a start held through the done cycle.
    push_exp(16'h0000, 1'b1, 1'b0);
    issue(16'h9999, 16'h0001, 1'b0);
    wait_done("wrap", DIGITS + 1);
    a      = 16'h1111;
    b      = 16'h2222;
    op_sub = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_ignored_idle", 32'(busy),   32'(0));
    check("b2b_ignored_held", 32'(result), 32'(16'h0000));
    push_exp(16'h3333, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("b2b", DIGITS + 1);
    post_check("b2b", 16'h3333);

    run_op("sub_pos",   16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, DIGITS + 1);
    run_op("sub_neg",   16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b0, DIGITS + 1);
    run_op("sub_zero",  16'h0042, 16'h0042, 1'b1, 16'h0000, 1'b1, 1'b0, DIGITS + 1);
    run_op("bad_a",     16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
    run_op("clear_err", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, DIGITS + 1);
    run_op("bad_b",     16'h0001, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1, 1);

    // Reset after two RUN edges aborts with no done pulse.
    issue(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy",   32'(busy),   32'(0));
    check("abort_done",   32'(done),   32'(0));
    check("abort_result", 32'(result), 32'(0));
    check("abort_cout",   32'(cout),   32'(0));
    check("abort_err",    32'(err),    32'(0));
    no_done_for("abort_no_done", 10);
    run_op("after_abort", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, DIGITS + 1);

    // Input changes and a start pulse during RUN must not disturb the operation.
    push_exp(16'h0579, 1'b0, 1'b0);
    issue(16'h0123, 16'h0456, 1'b0);
    @(negedge clk);
    a      = 16'h9999;
    b      = 16'h9999;
    op_sub = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("midrun", DIGITS);
    post_check("midrun", 16'h0579);
    no_done_for("midrun_single_done", 10);

    check("scoreboard_drain", 32'(sb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
